maze_engine: RTL and testbench
==============================

Name: maze_engine

Overview:
- Parametrised successor to the fixed-level maze controller.
- Maze geometry lives in a run-time-loadable rectangle table, so any level can be loaded without RTL changes.
- Moves the player one step per frame tick, checks legality against the table sequentially, and detects finish.
- Renders the VGA pixel colour for the current (col,row). Sits between level-select/tilt logic and the VGA timing generator.

Parameters:
- NUM_RECTS, 16, number of rectangle table entries (>=2).
- PLAYER_SIZE, 25, player square side in pixels.
- STEP, 2, pixels moved per frame tick per axis.
- SCREEN_W, 640, column limit; candidate x saturates to SCREEN_W-PLAYER_SIZE.
- SCREEN_H, 480, row limit; candidate y saturates to SCREEN_H-PLAYER_SIZE.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- level_lock  in  1  1 = play loaded level; 0 = return to IDLE
- frame_tick  in  1  one-cycle pulse per video frame
- dir_up, dir_down, dir_left, dir_right  in  1 each  movement request
- restart  in  1  one-cycle pulse; leave FINISH
- cfg_we  in  1  rectangle table write strobe
- cfg_idx  in  $clog2(NUM_RECTS)  entry index
- cfg_x, cfg_w  in  10 each  rectangle left edge / width
- cfg_y, cfg_h  in  9 each  rectangle top edge / height
- cfg_kind  in  2  0 unused, 1 path, 2 start, 3 finish
- start_x  in  10, start_y  in  9  player spawn, sampled on IDLE exit
- col  in  10, row  in  9  current pixel
- red, green, blue  out  4 each  pixel colour
- player_x  out  10, player_y  out  9  current position
- busy  out  1  high in CHECK
- collision  out  1  one-cycle pulse on illegal move
- finished  out  1  high while in FINISH

Behaviour:
- Reset: FSM=IDLE; all table kinds=0; player_x/y=0; rgb=0; collision=0; busy=0; finished=0.
- Table writes are accepted only in IDLE and ignored in other states.
- Walkable = kind 1, 2 or 3. Rectangle contains (c,r) iff x<=c<x+w and y<=r<y+h; sums are computed at 11/10 bits, with no wrap.
- IDLE:
  - level_lock=1 -> player:=start, go READY next cycle.
- READY:
  - frame_tick with net movement -> compute candidate, go CHECK.
  - Net dx: +STEP if right&!left, -STEP if left&!right, else 0. dy likewise for up/down.
  - Diagonals are allowed. Opposing requests cancel; net zero means no CHECK.
  - Candidate saturates at 0 and at the limit (no underflow).
- CHECK:
  - busy=1. Idx starts at 0, one entry per cycle; latency NUM_RECTS cycles.
  - 4 corner-hit flags: (cx,cy), (cx+S-1,cy), (cx,cy+S-1), (cx+S-1,cy+S-1). Each flag is set if that corner lies in any walkable entry.
  - fin flag: set if candidate box overlaps any kind-3 entry.
  - After the last entry:
    - All 4 corners hit -> commit candidate. Go FINISH if fin, else READY.
    - Otherwise -> player:=start, collision=1 for one cycle, READY.
  - frame_tick and direction inputs are ignored during CHECK.
- FINISH:
  - finished=1; movement is ignored.
  - restart -> player:=start, READY.
  - restart is ignored in other states.
- level_lock=0 in any non-IDLE state -> IDLE next cycle. This abandons CHECK with no commit and no collision pulse.
- Render (registered, 1-cycle latency from col/row), priority order:
  1. Player square (not in IDLE): magenta F,0,F.
  2. Lowest-index matching entry: finish F,0,0; start 0,F,0; path F,F,F.
  3. Otherwise: black.
  - Unused entries never match. The maze renders in IDLE too.

Test Plan:
- Reset, write path (100,100,50,380) and start (100,430,50,50) kind 2, start=(113,443), lock -> READY, player=(113,443); col=113,row=443 -> rgb F,0,F one cycle later.
- dir_up + frame_tick -> busy for exactly 16 cycles, then player=(113,441), collision stays 0.
- dir_left held for 7 ticks from x=113 (box exits path at x=99) -> 7th check fails, collision pulses once, player=(113,443).
- Finish rect kind 3 at (100,100,50,50), player moved to y=150 then up one step -> y=148 committed, finished=1; dir inputs ignored; restart -> player=(113,443), finished=0.
- dir_left&dir_right with frame_tick -> no CHECK, busy stays 0, position unchanged; x=1 with left -> candidate x=0 (saturated).
- cfg_we in READY -> table unchanged; level_lock dropped mid-CHECK -> IDLE next cycle, no collision, player not drawn.

Source files
------------

// File: rtl/maze_engine.sv
// Maze game engine: rectangle-table maze, per-frame player stepping with sequential legality check, finish detect, pixel render.
// Legality check takes NUM_RECTS cycles per move; pixel colour is registered one cycle after col/row.
module maze_engine #(
  parameter int NUM_RECTS   = 16,
  parameter int PLAYER_SIZE = 25,
  parameter int STEP        = 2,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         level_lock,
  input  logic                         frame_tick,
  input  logic                         dir_up,
  input  logic                         dir_down,
  input  logic                         dir_left,
  input  logic                         dir_right,
  input  logic                         restart,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_RECTS)-1:0] cfg_idx,
  input  logic [9:0]                   cfg_x,
  input  logic [9:0]                   cfg_w,
  input  logic [8:0]                   cfg_y,
  input  logic [8:0]                   cfg_h,
  input  logic [1:0]                   cfg_kind,
  input  logic [9:0]                   start_x,
  input  logic [8:0]                   start_y,
  input  logic [9:0]                   col,
  input  logic [8:0]                   row,
  output logic [3:0]                   red,
  output logic [3:0]                   green,
  output logic [3:0]                   blue,
  output logic [9:0]                   player_x,
  output logic [8:0]                   player_y,
  output logic                         busy,
  output logic                         collision,
  output logic                         finished
);

  localparam int IW = $clog2(NUM_RECTS);
  localparam logic [IW-1:0] LAST   = IW'(NUM_RECTS - 1);
  localparam logic [9:0]    X_LIM  = 10'(SCREEN_W - PLAYER_SIZE);
  localparam logic [8:0]    Y_LIM  = 9'(SCREEN_H - PLAYER_SIZE);
  localparam logic [9:0]    STEP_X = 10'(STEP);
  localparam logic [8:0]    STEP_Y = 9'(STEP);
  localparam logic [10:0]   SZ_X   = 11'(PLAYER_SIZE);
  localparam logic [9:0]    SZ_Y   = 10'(PLAYER_SIZE);
  localparam logic [1:0]    K_PATH = 2'd1;
  localparam logic [1:0]    K_START = 2'd2;
  localparam logic [1:0]    K_FIN  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_READY, S_CHECK, S_FINISH} state_t;

  state_t state_q, state_d;

  logic [9:0] rx [NUM_RECTS];
  logic [9:0] rw [NUM_RECTS];
  logic [8:0] ry [NUM_RECTS];
  logic [8:0] rh [NUM_RECTS];
  logic [1:0] rk [NUM_RECTS];

  logic [IW-1:0] idx;
  logic [3:0]    hit;
  logic          fin;
  logic [9:0]    cx;
  logic [8:0]    cy;

  // Point-in-rectangle with widened sums so x+w / y+h never wrap.
  function automatic logic in_rect(input logic [10:0] c, input logic [9:0] r,
                                   input logic [9:0] x, input logic [9:0] w,
                                   input logic [8:0] y, input logic [8:0] h);
    return ({1'b0, x} <= c) && (c < ({1'b0, x} + {1'b0, w})) &&
           ({1'b0, y} <= r) && (r < ({1'b0, y} + {1'b0, h}));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_RECTS; i++) rk[i] <= 2'd0;
    end else if (cfg_we && state_q == S_IDLE && int'(cfg_idx) < NUM_RECTS) begin
      rk[cfg_idx] <= cfg_kind;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we && state_q == S_IDLE && int'(cfg_idx) < NUM_RECTS) begin
      rx[cfg_idx] <= cfg_x;
      rw[cfg_idx] <= cfg_w;
      ry[cfg_idx] <= cfg_y;
      rh[cfg_idx] <= cfg_h;
    end
  end

  // Candidate position with saturation at 0 and at the screen limit.
  logic       mv_r, mv_l, mv_u, mv_d, move;
  logic [9:0] nx;
  logic [8:0] ny;

  always_comb begin
    mv_r = dir_right & ~dir_left;
    mv_l = dir_left & ~dir_right;
    mv_u = dir_up & ~dir_down;
    mv_d = dir_down & ~dir_up;
    move = mv_r | mv_l | mv_u | mv_d;
    nx   = player_x;
    ny   = player_y;
    if (mv_r)      nx = (player_x >= X_LIM - STEP_X) ? X_LIM : player_x + STEP_X;
    else if (mv_l) nx = (player_x <= STEP_X) ? 10'd0 : player_x - STEP_X;
    if (mv_d)      ny = (player_y >= Y_LIM - STEP_Y) ? Y_LIM : player_y + STEP_Y;
    else if (mv_u) ny = (player_y <= STEP_Y) ? 9'd0 : player_y - STEP_Y;
  end

  logic [10:0] cxl, cxr;
  logic [9:0]  cyt, cyb;
  logic        walk;
  logic [3:0]  cur_hit, hit_all;
  logic        cur_fin, fin_all;

  always_comb begin
    cxl  = {1'b0, cx};
    cxr  = {1'b0, cx} + SZ_X - 11'd1;
    cyt  = {1'b0, cy};
    cyb  = {1'b0, cy} + SZ_Y - 10'd1;
    walk = (rk[idx] != 2'd0);
    cur_hit[0] = walk && in_rect(cxl, cyt, rx[idx], rw[idx], ry[idx], rh[idx]);
    cur_hit[1] = walk && in_rect(cxr, cyt, rx[idx], rw[idx], ry[idx], rh[idx]);
    cur_hit[2] = walk && in_rect(cxl, cyb, rx[idx], rw[idx], ry[idx], rh[idx]);
    cur_hit[3] = walk && in_rect(cxr, cyb, rx[idx], rw[idx], ry[idx], rh[idx]);
    cur_fin = (rk[idx] == K_FIN) &&
              (cxl < {1'b0, rx[idx]} + {1'b0, rw[idx]}) && ({1'b0, rx[idx]} < cxl + SZ_X) &&
              (cyt < {1'b0, ry[idx]} + {1'b0, rh[idx]}) && ({1'b0, ry[idx]} < cyt + SZ_Y);
    hit_all = hit | cur_hit;
    fin_all = fin | cur_fin;
  end

  logic load_start, start_check, commit, coll_d;

  always_comb begin
    state_d     = state_q;
    load_start  = 1'b0;
    start_check = 1'b0;
    commit      = 1'b0;
    coll_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_lock) begin
          load_start = 1'b1;
          state_d    = S_READY;
        end
      end
      S_READY: begin
        if (frame_tick && move) begin
          start_check = 1'b1;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (idx == LAST) begin
          if (&hit_all) begin
            commit  = 1'b1;
            state_d = fin_all ? S_FINISH : S_READY;
          end else begin
            load_start = 1'b1;
            coll_d     = 1'b1;
            state_d    = S_READY;
          end
        end
      end
      S_FINISH: begin
        if (restart) begin
          load_start = 1'b1;
          state_d    = S_READY;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Unlocking abandons whatever is in flight, including a pending commit.
    if (!level_lock && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      load_start  = 1'b0;
      start_check = 1'b0;
      commit      = 1'b0;
      coll_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      player_x  <= 10'd0;
      player_y  <= 9'd0;
      collision <= 1'b0;
      idx       <= '0;
      hit       <= 4'd0;
      fin       <= 1'b0;
      cx        <= 10'd0;
      cy        <= 9'd0;
    end else begin
      state_q   <= state_d;
      collision <= coll_d;
      if (load_start) begin
        player_x <= start_x;
        player_y <= start_y;
      end else if (commit) begin
        player_x <= cx;
        player_y <= cy;
      end
      if (start_check) begin
        cx  <= nx;
        cy  <= ny;
        idx <= '0;
        hit <= 4'd0;
        fin <= 1'b0;
      end else if (state_q == S_CHECK) begin
        idx <= idx + 1'b1;
        hit <= hit_all;
        fin <= fin_all;
      end
    end
  end

  assign busy     = (state_q == S_CHECK);
  assign finished = (state_q == S_FINISH);

  logic [11:0] tbl_rgb, rgb_d;
  logic        player_px;

  always_comb begin
    tbl_rgb = 12'h000;
    // Descending scan so the lowest matching index wins.
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      if (rk[i] != 2'd0 && in_rect({1'b0, col}, {1'b0, row}, rx[i], rw[i], ry[i], rh[i])) begin
        case (rk[i])
          K_FIN:   tbl_rgb = 12'hF00;
          K_START: tbl_rgb = 12'h0F0;
          K_PATH:  tbl_rgb = 12'hFFF;
          default: tbl_rgb = 12'h000;
        endcase
      end
    end
    player_px = (state_q != S_IDLE) &&
                (col >= player_x) && ({1'b0, col} < {1'b0, player_x} + SZ_X) &&
                (row >= player_y) && ({1'b0, row} < {1'b0, player_y} + SZ_Y);
    rgb_d = player_px ? 12'hF0F : tbl_rgb;
  end

  always_ff @(posedge clk) begin
    if (reset) {red, green, blue} <= 12'h000;
    else       {red, green, blue} <= rgb_d;
  end

endmodule

// File: tb/tb_maze_engine.sv
// Directed bench for maze_engine: scoreboard queue of expected results, immediate assertions at each check point.
module tb_maze_engine;

  logic       clk = 1'b0;
  logic       reset, level_lock, frame_tick, restart, cfg_we;
  logic       dir_up, dir_down, dir_left, dir_right;
  logic [3:0] cfg_idx;
  logic [9:0] cfg_x, cfg_w, start_x, col;
  logic [8:0] cfg_y, cfg_h, start_y, row;
  logic [1:0] cfg_kind;
  logic [3:0] red, green, blue;
  logic [9:0] player_x;
  logic [8:0] player_y;
  logic       busy, collision, finished;

  int n_assert = 0;
  int n_fail   = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  maze_engine dut (
    .clk(clk), .reset(reset), .level_lock(level_lock), .frame_tick(frame_tick),
    .dir_up(dir_up), .dir_down(dir_down), .dir_left(dir_left), .dir_right(dir_right),
    .restart(restart), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_w(cfg_w), .cfg_y(cfg_y), .cfg_h(cfg_h), .cfg_kind(cfg_kind),
    .start_x(start_x), .start_y(start_y), .col(col), .row(row),
    .red(red), .green(green), .blue(blue),
    .player_x(player_x), .player_y(player_y),
    .busy(busy), .collision(collision), .finished(finished)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h expected none", obs);
    end else begin
      chk(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic wr(input int idx, input int x, input int y, input int w, input int h, input int kind);
    cfg_idx  = 4'(idx);
    cfg_x    = 10'(x);
    cfg_y    = 9'(y);
    cfg_w    = 10'(w);
    cfg_h    = 9'(h);
    cfg_kind = 2'(kind);
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic render(input int c, input int r, input logic [11:0] exp);
    col = 10'(c);
    row = 9'(r);
    push("rgb", 32'(exp));
    tick();
    pop_chk(32'({red, green, blue}));
  endtask

  // One frame tick with the given directions; waits (bounded) for the check to end.
  task automatic move(input logic u, input logic d, input logic l, input logic r,
                      output int cycles, output logic coll);
    dir_up = u; dir_down = d; dir_left = l; dir_right = r;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    dir_up = 0; dir_down = 0; dir_left = 0; dir_right = 0;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      tick();
    end
    coll = collision;
  endtask

  task automatic lock_at(input int x, input int y);
    start_x = 10'(x);
    start_y = 9'(y);
    level_lock = 1'b1;
    push("lock_px", 32'(x));
    push("lock_py", 32'(y));
    tick();
    pop_chk(32'(player_x));
    pop_chk(32'(player_y));
  endtask

  task automatic unlock();
    level_lock = 1'b0;
    tick();
  endtask

  initial begin : stim
    int   cyc;
    logic coll;
    logic any_coll;
    reset = 1; level_lock = 0; frame_tick = 0; restart = 0; cfg_we = 0;
    dir_up = 0; dir_down = 0; dir_left = 0; dir_right = 0;
    cfg_idx = 0; cfg_x = 0; cfg_y = 0; cfg_w = 0; cfg_h = 0; cfg_kind = 0;
    start_x = 0; start_y = 0; col = 0; row = 0;
    repeat (3) tick();
    chk("rst_px", player_x, 0);
    chk("rst_py", player_y, 0);
    chk("rst_rgb", {red, green, blue}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_coll", collision, 0);
    chk("rst_fin", finished, 0);
    reset = 0;
    tick();

    // Path column plus start pad; maze visible while still IDLE.
    wr(0, 100, 100, 50, 380, 1);
    wr(1, 100, 430, 50, 50, 2);
    render(120, 200, 12'hFFF);
    render(5, 5, 12'h000);

    lock_at(113, 443);
    chk("ready_busy", busy, 0);
    render(113, 443, 12'hF0F);
    render(145, 470, 12'hFFF);

    push("up_px", 113); push("up_py", 441);
    move(1, 0, 0, 0, cyc, coll);
    chk("up_busy_cycles", cyc, 16);
    chk("up_coll", coll, 0);
    pop_chk(player_x); pop_chk(player_y);

    // Walk left until the box leaves the path column at x=99.
    for (int k = 1; k <= 7; k++) begin
      if (k < 7) begin
        push("left_px", 32'(113 - 2 * k)); push("left_py", 441);
      end else begin
        push("left_px", 113); push("left_py", 443);
      end
      move(0, 0, 1, 0, cyc, coll);
      chk("left_coll", coll, (k == 7) ? 1 : 0);
      pop_chk(player_x); pop_chk(player_y);
    end
    tick();
    chk("coll_one_cycle", collision, 0);

    // Finish region at the top of the column.
    unlock();
    wr(2, 100, 100, 50, 50, 3);
    lock_at(113, 150);
    start_y = 9'd443;
    push("fin_py", 148);
    move(1, 0, 0, 0, cyc, coll);
    chk("fin_coll", coll, 0);
    pop_chk(player_y);
    chk("fin_flag", finished, 1);
    move(0, 0, 1, 0, cyc, coll);
    chk("fin_no_check", cyc, 0);
    chk("fin_hold_px", player_x, 113);
    chk("fin_hold_flag", finished, 1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_px", player_x, 113);
    chk("restart_py", player_y, 443);
    chk("restart_fin", finished, 0);

    move(0, 0, 1, 1, cyc, coll);
    chk("cancel_busy", cyc, 0);
    chk("cancel_px", player_x, 113);
    chk("cancel_py", player_y, 443);

    // Whole screen walkable to probe saturation at both edges.
    unlock();
    wr(3, 0, 0, 640, 480, 1);
    lock_at(1, 1);
    push("sat0_px", 0); push("sat0_py", 0);
    move(1, 0, 1, 0, cyc, coll);
    chk("sat0_coll", coll, 0);
    pop_chk(player_x); pop_chk(player_y);
    unlock();
    lock_at(614, 454);
    push("satmax_px", 615); push("satmax_py", 455);
    move(0, 1, 0, 1, cyc, coll);
    chk("satmax_coll", coll, 0);
    pop_chk(player_x); pop_chk(player_y);

    wr(3, 0, 0, 640, 480, 0);
    render(5, 5, 12'hFFF);

    // Unlock during a check: no commit, no pulse, player hidden.
    dir_left = 1'b1;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    dir_left = 1'b0;
    chk("abort_busy_on", busy, 1);
    tick();
    tick();
    level_lock = 1'b0;
    tick();
    chk("abort_busy_off", busy, 0);
    chk("abort_coll", collision, 0);
    chk("abort_px", player_x, 615);
    render(620, 460, 12'hFFF);
    any_coll = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      any_coll = any_coll | collision;
    end
    chk("abort_no_late_coll", any_coll, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
